// File: rtl/booth_ctrl.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath: issues one command per
// cycle, tracks q(-1), runs the start/busy/done handshake and latches the product.
module booth_ctrl #(
  parameter int BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [1:0]             status,
  input  logic                   ef,
  input  logic [2*BIT_LEN-1:0]   dp_result,
  output logic [1:0]             control,
  output logic                   busy,
  output logic                   done,
  output logic [2*BIT_LEN-1:0]   result,
  output logic                   err
);

  // state | meaning
  // IDLE  | datapath reloads operands every cycle, waiting for start
  // STEP  | examine {B[0], q(-1)}: add/sub, shift, or finish on count zero
  // SHIFT | shift that follows an ADD or SUB
  // DONE  | one-cycle completion pulse, start ignored
  typedef enum logic [1:0] {IDLE, STEP, SHIFT, DONE} state_t;

  localparam logic [1:0] CMD_INIT  = 2'b00;
  localparam logic [1:0] CMD_ADD   = 2'b01;
  localparam logic [1:0] CMD_SUB   = 2'b10;
  localparam logic [1:0] CMD_SHIFT = 2'b11;

  state_t                 state_q, state_d;
  logic                   q_m1_q, q_m1_d;
  logic [2*BIT_LEN-1:0]   result_q, result_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      q_m1_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_m1_q   <= q_m1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_m1_d   = q_m1_q;
    result_d = result_q;
    err_d    = err_q;
    control  = CMD_INIT;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STEP;
          q_m1_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      STEP: begin
        if (status[0]) begin
          // Capture on the same edge the INIT reload happens; dp_result is still the product.
          result_d = dp_result;
          state_d  = DONE;
        end else begin
          case ({status[1], q_m1_q})
            2'b10: begin
              control = CMD_SUB;
              state_d = SHIFT;
            end
            2'b01: begin
              control = CMD_ADD;
              state_d = SHIFT;
            end
            default: begin
              control = CMD_SHIFT;
              q_m1_d  = status[1];
            end
          endcase
        end
      end
      SHIFT: begin
        control = CMD_SHIFT;
        q_m1_d  = status[1];
        state_d = STEP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A datapath fault wins over the clear from an accepted start.
    if (ef) err_d = 1'b1;
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl driving a behavioural 4-bit Booth datapath model.
module tb_booth_ctrl;

  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      status;
  logic            ef;
  logic [2*BL-1:0] dp_result;
  logic [1:0]      control;
  logic            busy, done, err;
  logic [2*BL-1:0] result;

  booth_ctrl #(.BIT_LEN(BL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .status(status), .ef(ef),
    .dp_result(dp_result), .control(control), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // datapath model: X accumulator, B multiplier, A multiplicand, shift count
  logic [BL-1:0] a_in = '0, b_in = '0;
  logic [BL-1:0] x_r = '0, b_r = '0, a_r = '0;
  int            cnt = BL;
  logic          ef_inj = 1'b0;

  assign status    = {b_r[0], cnt == 0};
  assign dp_result = {x_r, b_r};
  assign ef        = ((control == 2'b11) && (cnt == 0)) || ef_inj;

  always @(posedge clk) begin
    case (control)
      2'b00: begin x_r <= '0; b_r <= b_in; a_r <= a_in; cnt <= BL; end
      2'b01: x_r <= x_r + a_r;
      2'b10: x_r <= x_r - a_r;
      default: begin
        {x_r, b_r} <= {x_r[BL-1], x_r, b_r[BL-1:1]};
        if (cnt > 0) cnt <= cnt - 1;
      end
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // per-run observations
  logic [1:0]      seq [0:20];
  logic [2*BL-1:0] r_res;
  int              r_lat, r_busy_low, r_extra_done;
  logic            r_busy_after, r_err_done;

  task automatic run(input logic [BL-1:0] a, input logic [BL-1:0] b,
                     input int poke_start, input int poke_ef);
    a_in = a; b_in = b; start = 1'b1;
    seq[0] = control;
    @(posedge clk); #1 start = 1'b0;
    r_lat = -1; r_busy_low = 0;
    for (int i = 1; i <= 20; i++) begin
      seq[i] = control;
      start  = (i == poke_start);
      ef_inj = (i == poke_ef);
      if (!busy) r_busy_low++;
      @(posedge clk); #1;
      start = 1'b0; ef_inj = 1'b0;
      if (done) begin
        r_lat = i;
        break;
      end
    end
    r_res = result;
    r_err_done = err;
    if (!busy) r_busy_low++;
    r_extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) r_busy_after = busy;
      if (done) r_extra_done++;
    end
  endtask

  typedef struct {
    string         name;
    logic [BL-1:0] a, b;
    int            poke_start;
    logic [7:0]    exp_res;
    int            exp_lat;
    bit            chk_seq;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] exp_seq [0:7];

  initial begin
    vecs[0] = '{"t1_3x6",    4'h3, 4'h6, 0, 8'h12, 7, 1'b1};
    vecs[1] = '{"t2_m3x6",   4'hD, 4'h6, 0, 8'hEE, 7, 1'b1};
    vecs[2] = '{"t3_5x0",    4'h5, 4'h0, 0, 8'h00, 5, 1'b0};
    vecs[3] = '{"t4_7xm8",   4'h7, 4'h8, 3, 8'hC8, 6, 1'b0};
    vecs[4] = '{"2x3",       4'h2, 4'h3, 0, 8'h06, 7, 1'b0};
    vecs[5] = '{"m1xm1",     4'hF, 4'hF, 0, 8'h01, 6, 1'b0};
    exp_seq = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00};

    #2;
    chk("rst_control", control, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      run(vecs[v].a, vecs[v].b, vecs[v].poke_start, 0);
      chk({vecs[v].name, "_latency"}, r_lat, vecs[v].exp_lat);
      chk({vecs[v].name, "_result"}, r_res, vecs[v].exp_res);
      chk({vecs[v].name, "_busy_low"}, r_busy_low, 0);
      chk({vecs[v].name, "_busy_after"}, r_busy_after, 0);
      chk({vecs[v].name, "_extra_done"}, r_extra_done, 0);
      chk({vecs[v].name, "_result_held"}, result, vecs[v].exp_res);
      if (vecs[v].chk_seq)
        for (int i = 0; i <= 7; i++)
          chk($sformatf("%s_seq%0d", vecs[v].name, i), seq[i], exp_seq[i]);
    end

    // back-to-back: start held through DONE is ignored there, accepted in following IDLE
    a_in = 4'h3; b_in = 4'h6; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !done; i++) begin @(posedge clk); #1; end
    chk("b2b_done", done, 1);
    chk("b2b_result", result, 8'h12);
    @(posedge clk); #1;
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    chk("b2b_second_idle", busy, 0);
    chk("b2b_second_result", result, 8'h12);

    // T5: reset during the 3rd cycle of a run
    a_in = 4'h7; b_in = 4'h3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk("t5_rst_control", control, 2'b00);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_result", result, 0);
    chk("t5_rst_done", done, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_no_done", done, 0);
    end
    run(4'h7, 4'h3, 0, 0);
    chk("t5_after_result", r_res, 8'h15);
    chk("t5_after_latency", r_lat, 7);

    // T6: injected end flag is sticky until the next accepted start
    run(4'h3, 4'h6, 0, 2);
    chk("t6_err_at_done", r_err_done, 1);
    chk("t6_result", r_res, 8'h12);
    chk("t6_err_held", err, 1);
    a_in = 4'h2; b_in = 4'h3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_err_cleared", err, 0);
    r_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin r_lat = i; break; end
    end
    chk("t6_next_latency", r_lat, 7);
    chk("t6_next_result", result, 8'h06);
    chk("t6_next_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
